// File: rtl/axi4lite_pkg.sv
// Shared definitions for the AXI4-Lite master: FSM state encoding and response codes.
package axi4lite_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWr     = 3'd1,
    StWrResp = 3'd2,
    StRdAddr = 3'd3,
    StRdData = 3'd4
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi4lite_master_v2_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4lite_master_v2_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi4lite_timeout.sv
// Per-transaction watchdog: expired is high in the TIMEOUT-th enabled cycle after clr.
module axi4lite_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned    CntW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit             Enabled = (TIMEOUT != 0);
  localparam logic [CntW-1:0] Last   = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;

  assign expired = Enabled && en && (r_cnt == Last);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr) begin
      w_cnt_nxt = '0;
    end else if (en && !expired) begin
      w_cnt_nxt = r_cnt + CntW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/axi4lite_master_v2.sv
// Single-outstanding AXI4-Lite master with round-robin read/write arbitration and timeout.
module axi4lite_master_v2 #(
  parameter  int unsigned ADDR_W  = 8,
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned TIMEOUT = 255,
  localparam int unsigned STRB_W  = DATA_W / 8
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  axi4lite_master_v2_if.master  m_axi,
  input  logic                  wr_req,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [STRB_W-1:0]     wr_strb,
  input  logic                  rd_req,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  done_rd,
  output logic [1:0]            resp,
  output logic                  timeout_err,
  output logic [DATA_W-1:0]     rd_data
);
  import axi4lite_pkg::*;

  state_e            r_state, w_state_nxt;
  logic              r_prio_rd, w_prio_rd_nxt;
  logic [ADDR_W-1:0] r_awaddr, w_awaddr_nxt, r_araddr, w_araddr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt, r_rd_data, w_rd_data_nxt;
  logic [STRB_W-1:0] r_wstrb, w_wstrb_nxt;
  logic              r_awvalid, w_awvalid_nxt, r_wvalid, w_wvalid_nxt;
  logic              r_arvalid, w_arvalid_nxt;
  logic              r_done, w_done_nxt, r_done_rd, w_done_rd_nxt;
  logic              r_timeout_err, w_timeout_err_nxt;
  logic [1:0]        r_resp, w_resp_nxt;
  logic              w_grant, w_expired, w_bready, w_rready;
  logic              w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  assign w_bready = (r_state == StWrResp);
  assign w_rready = (r_state == StRdData);
  assign w_grant  = (r_state == StIdle) && (wr_req || rd_req);
  assign w_aw_hs  = r_awvalid & m_axi.awready;
  assign w_w_hs   = r_wvalid & m_axi.wready;
  assign w_b_hs   = w_bready & m_axi.bvalid;
  assign w_ar_hs  = r_arvalid & m_axi.arready;
  assign w_r_hs   = w_rready & m_axi.rvalid;

  axi4lite_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk   (m_axi_aclk),
    .i_rst_n (m_axi_aresetn),
    .clr     (w_grant),
    .en      (r_state != StIdle),
    .expired (w_expired)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_prio_rd_nxt     = r_prio_rd;
    w_awaddr_nxt      = r_awaddr;
    w_araddr_nxt      = r_araddr;
    w_wdata_nxt       = r_wdata;
    w_wstrb_nxt       = r_wstrb;
    w_rd_data_nxt     = r_rd_data;
    w_awvalid_nxt     = r_awvalid;
    w_wvalid_nxt      = r_wvalid;
    w_arvalid_nxt     = r_arvalid;
    w_done_nxt        = 1'b0;
    w_done_rd_nxt     = r_done_rd;
    w_timeout_err_nxt = r_timeout_err;
    w_resp_nxt        = r_resp;

    unique case (r_state)
      StIdle: begin
        // r_prio_rd set means a write was granted last, so a read wins a tie
        if (wr_req && (!rd_req || !r_prio_rd)) begin
          w_state_nxt   = StWr;
          w_awaddr_nxt  = wr_addr;
          w_wdata_nxt   = wr_data;
          w_wstrb_nxt   = wr_strb;
          w_awvalid_nxt = 1'b1;
          w_wvalid_nxt  = 1'b1;
          w_prio_rd_nxt = 1'b1;
        end else if (rd_req) begin
          w_state_nxt   = StRdAddr;
          w_araddr_nxt  = rd_addr;
          w_arvalid_nxt = 1'b1;
          w_prio_rd_nxt = 1'b0;
        end
      end
      StWr: begin
        if (w_aw_hs) w_awvalid_nxt = 1'b0;
        if (w_w_hs)  w_wvalid_nxt  = 1'b0;
        if ((w_aw_hs || !r_awvalid) && (w_w_hs || !r_wvalid)) w_state_nxt = StWrResp;
      end
      StWrResp: begin
        if (w_b_hs) begin
          w_state_nxt       = StIdle;
          w_done_nxt        = 1'b1;
          w_done_rd_nxt     = 1'b0;
          w_timeout_err_nxt = 1'b0;
          w_resp_nxt        = m_axi.bresp;
        end
      end
      StRdAddr: begin
        if (w_ar_hs) begin
          w_arvalid_nxt = 1'b0;
          w_state_nxt   = StRdData;
        end
      end
      StRdData: begin
        if (w_r_hs) begin
          w_state_nxt       = StIdle;
          w_done_nxt        = 1'b1;
          w_done_rd_nxt     = 1'b1;
          w_timeout_err_nxt = 1'b0;
          w_resp_nxt        = m_axi.rresp;
          w_rd_data_nxt     = m_axi.rdata;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // A completing B/R handshake beats the watchdog in the same cycle
    if (w_expired && !w_b_hs && !w_r_hs) begin
      w_state_nxt       = StIdle;
      w_awvalid_nxt     = 1'b0;
      w_wvalid_nxt      = 1'b0;
      w_arvalid_nxt     = 1'b0;
      w_done_nxt        = 1'b1;
      w_done_rd_nxt     = (r_state == StRdAddr) || (r_state == StRdData);
      w_timeout_err_nxt = 1'b1;
      w_resp_nxt        = SLVERR;
    end
  end

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      r_state       <= StIdle;
      r_prio_rd     <= 1'b0;
      r_awaddr      <= '0;
      r_araddr      <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '1;
      r_rd_data     <= '0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_done        <= 1'b0;
      r_done_rd     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_resp        <= OKAY;
    end else begin
      r_state       <= w_state_nxt;
      r_prio_rd     <= w_prio_rd_nxt;
      r_awaddr      <= w_awaddr_nxt;
      r_araddr      <= w_araddr_nxt;
      r_wdata       <= w_wdata_nxt;
      r_wstrb       <= w_wstrb_nxt;
      r_rd_data     <= w_rd_data_nxt;
      r_awvalid     <= w_awvalid_nxt;
      r_wvalid      <= w_wvalid_nxt;
      r_arvalid     <= w_arvalid_nxt;
      r_done        <= w_done_nxt;
      r_done_rd     <= w_done_rd_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_resp        <= w_resp_nxt;
    end
  end

  assign m_axi.awaddr  = r_awaddr;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.bready  = w_bready;
  assign m_axi.araddr  = r_araddr;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.rready  = w_rready;

  assign busy        = (r_state != StIdle);
  assign done        = r_done;
  assign done_rd     = r_done_rd;
  assign resp        = r_resp;
  assign timeout_err = r_timeout_err;
  assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_axi4lite_master_v2.sv
// Directed bench for axi4lite_master_v2: one default instance plus one with TIMEOUT=4.
module tb_axi4lite_master_v2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic        wr_req, rd_req;
  logic [7:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        busy, done, done_rd, timeout_err;
  logic [1:0]  resp;
  logic [31:0] rd_data;

  logic        t_wr_req, t_rd_req;
  logic [7:0]  t_wr_addr, t_rd_addr;
  logic [31:0] t_wr_data;
  logic [3:0]  t_wr_strb;
  logic        t_busy, t_done, t_done_rd, t_timeout_err;
  logic [1:0]  t_resp;
  logic [31:0] t_rd_data;

  axi4lite_master_v2_if #(.ADDR_W(8), .DATA_W(32)) bus ();
  axi4lite_master_v2_if #(.ADDR_W(8), .DATA_W(32)) bus_t ();

  axi4lite_master_v2 #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(255)) dut (
    .m_axi_aclk (clk), .m_axi_aresetn (rst_n), .m_axi (bus),
    .wr_req (wr_req), .wr_addr (wr_addr), .wr_data (wr_data), .wr_strb (wr_strb),
    .rd_req (rd_req), .rd_addr (rd_addr),
    .busy (busy), .done (done), .done_rd (done_rd), .resp (resp),
    .timeout_err (timeout_err), .rd_data (rd_data)
  );

  axi4lite_master_v2 #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(4)) dut_to (
    .m_axi_aclk (clk), .m_axi_aresetn (rst_n), .m_axi (bus_t),
    .wr_req (t_wr_req), .wr_addr (t_wr_addr), .wr_data (t_wr_data), .wr_strb (t_wr_strb),
    .rd_req (t_rd_req), .rd_addr (t_rd_addr),
    .busy (t_busy), .done (t_done), .done_rd (t_done_rd), .resp (t_resp),
    .timeout_err (t_timeout_err), .rd_data (t_rd_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rresp = 0; bus.rdata = 0;
  endtask

  // Always-ready slave until done is seen (bounded)
  task automatic serve(input string tag, input logic [1:0] code, input logic [31:0] rdat);
    int n;
    bus.awready = 1; bus.wready = 1; bus.arready = 1; bus.bvalid = 1; bus.rvalid = 1;
    bus.bresp = code; bus.rresp = code; bus.rdata = rdat;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    slave_idle();
    check(tag, done, 1'b1);
  endtask

  initial begin
    wr_req = 0; rd_req = 0; wr_addr = 0; rd_addr = 0; wr_data = 0; wr_strb = 0;
    t_wr_req = 0; t_rd_req = 0; t_wr_addr = 8'h40; t_rd_addr = 0; t_wr_data = 32'h55;
    t_wr_strb = 4'hF;
    slave_idle();
    bus_t.awready = 1; bus_t.wready = 1; bus_t.bvalid = 0; bus_t.bresp = 0;
    bus_t.arready = 0; bus_t.rvalid = 0; bus_t.rresp = 0; bus_t.rdata = 0;

    rst_n = 0; tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
    check("rst_wstrb", bus.wstrb, 4'hF);
    check("rst_resp", {resp, done_rd, timeout_err}, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1;

    // Write: awready arrives two cycles before wready
    wr_req = 1; wr_addr = 8'h10; wr_data = 32'hDEADBEEF; wr_strb = 4'hF;
    tick();
    wr_req = 0;
    check("wr_grant_valids", {bus.awvalid, bus.wvalid, busy}, 3'b111);
    check("wr_awaddr", bus.awaddr, 8'h10);
    check("wr_wdata", bus.wdata, 32'hDEADBEEF);
    tick();
    check("wr_hold", {bus.awvalid, bus.wvalid}, 2'b11);
    bus.awready = 1; tick(); bus.awready = 0;
    check("wr_aw_done", {bus.awvalid, bus.wvalid, bus.bready}, 3'b010);
    tick();
    check("wr_w_hold", {bus.wvalid, bus.wdata}, {1'b1, 32'hDEADBEEF});
    bus.wready = 1; tick(); bus.wready = 0;
    check("wr_resp_state", {bus.wvalid, bus.bready, done}, 3'b010);
    bus.bvalid = 1; bus.bresp = 2'b00; tick(); bus.bvalid = 0;
    check("wr_done", {done, done_rd, resp, busy, bus.bready}, 6'b100000);
    tick();
    check("wr_done_pulse", done, 0);

    // Read: arready three cycles late
    rd_req = 1; rd_addr = 8'h24;
    tick();
    rd_req = 0;
    check("rd_grant", {bus.arvalid, bus.awvalid, bus.araddr}, {2'b10, 8'h24});
    tick(); tick();
    check("rd_ar_hold", bus.arvalid, 1);
    bus.arready = 1; tick(); bus.arready = 0;
    check("rd_ar_done", {bus.arvalid, bus.rready}, 2'b01);
    bus.rvalid = 1; bus.rdata = 32'h12345678; bus.rresp = 2'b00; tick(); bus.rvalid = 0;
    check("rd_done", {done, done_rd, resp, timeout_err}, 5'b11000);
    check("rd_data", rd_data, 32'h12345678);
    tick();
    check("rd_hold", {done, done_rd, rd_data}, {2'b01, 32'h12345678});

    // Round robin with both requests high
    wr_req = 1; rd_req = 1; tick(); wr_req = 0; rd_req = 0;
    check("rr1_write", {bus.awvalid, bus.arvalid}, 2'b10);
    serve("rr1_serve", 2'b00, 32'h0);
    wr_req = 1; rd_req = 1; tick(); wr_req = 0; rd_req = 0;
    check("rr2_read", {bus.awvalid, bus.arvalid}, 2'b01);
    serve("rr2_serve", 2'b00, 32'hA5A5A5A5);
    check("rr2_done_rd", done_rd, 1);
    wr_req = 1; rd_req = 1; tick(); wr_req = 0; rd_req = 0;
    check("rr3_write", {bus.awvalid, bus.arvalid}, 2'b10);
    serve("rr3_serve", 2'b00, 32'h0);

    // Error responses complete normally and report the code
    rd_req = 1; rd_addr = 8'h30; tick(); rd_req = 0;
    serve("decerr_serve", 2'b11, 32'hCAFEF00D);
    check("decerr_resp", {resp, done_rd, timeout_err}, 4'b1110);
    check("decerr_data", rd_data, 32'hCAFEF00D);
    tick();
    check("decerr_hold", {done, resp}, 3'b011);
    wr_req = 1; wr_addr = 8'h08; wr_data = 32'h1; tick(); wr_req = 0;
    serve("slverr_serve", 2'b10, 32'h0);
    check("slverr_resp", {resp, done_rd, timeout_err}, 4'b1000);
    check("slverr_rd_held", rd_data, 32'hCAFEF00D);

    // Reset during WR aborts without done; write wins right after release
    tick();
    wr_req = 1; wr_addr = 8'h77; wr_data = 32'h77; wr_strb = 4'h3; tick(); wr_req = 0;
    check("abort_in_wr", {bus.awvalid, bus.wstrb}, {1'b1, 4'h3});
    rst_n = 0; tick();
    check("abort_flags", {busy, done, done_rd, timeout_err, resp}, 0);
    check("abort_bus", {bus.awvalid, bus.wvalid, bus.awaddr, bus.wdata}, 0);
    check("abort_wstrb_data", {bus.wstrb, rd_data}, {4'hF, 32'h0});
    rst_n = 1;
    wr_req = 1; rd_req = 1; tick(); wr_req = 0; rd_req = 0;
    check("post_rst_write_wins", {bus.awvalid, bus.arvalid, busy}, 3'b101);
    serve("post_rst_serve", 2'b00, 32'h0);

    // Timeout instance: bvalid never comes
    t_wr_req = 1; tick(); t_wr_req = 0;
    check("to_grant", t_busy, 1);
    tick(); tick(); tick();
    check("to_not_yet", {t_busy, t_done}, 2'b10);
    tick();
    check("to_done", {t_done, t_timeout_err, t_resp, t_busy}, 5'b11100);
    check("to_bus_low", {bus_t.awvalid, bus_t.wvalid, bus_t.arvalid, bus_t.bready,
                         bus_t.rready}, 0);
    tick();
    check("to_pulse", {t_done, t_timeout_err}, 2'b01);

    // B handshake in the expiry cycle completes normally
    t_wr_req = 1; tick(); t_wr_req = 0;
    tick(); tick(); tick();
    bus_t.bvalid = 1; bus_t.bresp = 2'b00; tick(); bus_t.bvalid = 0;
    check("to_race_done", {t_done, t_timeout_err, t_resp}, 4'b1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/axi4lite_master_v2.md
AXI4LITE_MASTER_V2 -- requirements
Module: axi4lite_master_v2

Interface
REQ-001 Parameter ADDR_W, default 8: AXI address width in bits.
REQ-002 Parameter DATA_W, default 32: data width; legal values 8, 16, 32 or 64; STRB_W = DATA_W/8.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles waiting in any non-IDLE state; 0 disables the timeout.
REQ-004 m_axi_aclk  in  1  sole clock; all logic on the rising edge.
REQ-005 m_axi_aresetn  in  1  reset, synchronous, active-low.
REQ-006 m_axi_awaddr/awvalid  out  ADDR_W/1; m_axi_awready  in  1: write address channel.
REQ-007 m_axi_wdata/wstrb/wvalid  out  DATA_W/STRB_W/1; m_axi_wready  in  1: write data channel.
REQ-008 m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1: write response channel.
REQ-009 m_axi_araddr/arvalid  out  ADDR_W/1; m_axi_arready  in  1: read address channel.
REQ-010 m_axi_rdata  in  DATA_W; m_axi_rresp  in  2; m_axi_rvalid  in  1; m_axi_rready  out  1: read data channel.
REQ-011 wr_req  in  1; wr_addr  in  ADDR_W; wr_data  in  DATA_W; wr_strb  in  STRB_W: user write request.
REQ-012 rd_req  in  1; rd_addr  in  ADDR_W: user read request.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 done  out  1  one-cycle pulse on completion; done_rd  out  1  qualifies done (1 = read).
REQ-015 resp  out  2  completion response; timeout_err  out  1  completion was a timeout; rd_data  out  DATA_W  read result.

Function
REQ-016 States SHALL be IDLE, WR, WR_RESP, RD_ADDR, RD_DATA.
REQ-017 Requests SHALL be sampled only in IDLE; requests raised while busy are ignored, not queued.
REQ-018 If wr_req and rd_req are both high in IDLE, arbitration SHALL be round-robin: grant the type not granted last; after reset, write wins.
REQ-019 On grant, address, data and strobe SHALL be registered; the matching valid(s) rise the next cycle (1-cycle request-to-valid latency).
REQ-020 In WR, awvalid and wvalid SHALL rise together and each SHALL drop independently after its own handshake (valid&ready); WR exits to WR_RESP once both have completed, including both completing in the same cycle.
REQ-021 Every valid SHALL stay asserted with stable payload until its ready; valid never depends combinationally on ready.
REQ-022 bready SHALL be high throughout WR_RESP and rready throughout RD_DATA; on the handshake the FSM returns to IDLE.
REQ-023 On B/R handshake: done=1 the next cycle, resp=bresp/rresp, done_rd set accordingly; rd_data = rdata on reads and is held otherwise.
REQ-024 resp, done_rd, timeout_err and rd_data SHALL hold until the next completion.
REQ-025 SLVERR/DECERR responses SHALL complete normally with resp reporting the code; there is no retry.
REQ-026 With TIMEOUT>0, a per-transaction counter SHALL clear on grant and increment each non-IDLE cycle; reaching TIMEOUT forces IDLE, drops all valids/readies, and pulses done with timeout_err=1 and resp=2'b10.
REQ-027 A handshake in the same cycle as counter expiry SHALL take precedence: normal completion, timeout_err=0.
REQ-028 The master SHALL issue at most one outstanding transaction at any time.

Reset
REQ-029 While m_axi_aresetn=0 at a clock edge: state=IDLE; all valids/readies, done, done_rd and timeout_err = 0; resp=2'b00; addresses, wdata and rd_data = 0; wstrb = all ones; arbitration pointer = write.
REQ-030 Reset asserted mid-transaction SHALL abort it without a done pulse; the first request is accepted in the first cycle after release.

Structure
REQ-031 Shared package axi4lite_pkg SHALL hold the state encoding and the response constants OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11.
REQ-032 Timeout counter SHALL be a sub-module axi4lite_timeout (params TIMEOUT, width = clog2(TIMEOUT+1); ports clr, en, expired).

Verification
REQ-033 Write with wr_addr=0x10, wr_data=0xDEADBEEF, wr_strb=0xF, awready 2 cycles before wready, bresp=00 -> AW and W each held until ready, single done, done_rd=0, resp=00.
REQ-034 Read of addr 0x24 with arready delayed 3 cycles and rdata=0x12345678, rresp=00 -> rd_data=0x12345678, done_rd=1.
REQ-035 wr_req and rd_req high for two consecutive grants -> write, then read, then write.
REQ-036 TIMEOUT=4, bvalid never asserted -> done with timeout_err=1 and resp=10 at grant+4, all valids and readies low.
REQ-037 rresp=11 -> resp=11 and done pulse; reset applied during WR -> no done, all outputs at reset values the next cycle.
